// File: rtl/iq_capture_writer.sv
// iq_capture_writer: after arm+trigger, writes BUFFER_LENGTH I/Q samples to addresses 0.. and tracks write responses.
// Define IQ_CAPTURE_WRITER_DECIMATE_EN to keep only every DECIM_FACTOR-th captured sample.
module iq_capture_writer #(
  parameter int I_BITS = 16,
  parameter int Q_BITS = 16,
  parameter int BUFFER_LENGTH = 1024,
  parameter int INDEX_BITS = 10,
  parameter int DECIM_FACTOR = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     arm,
  input  logic                     trigger,
  input  logic [I_BITS-1:0]        in_i,
  input  logic [Q_BITS-1:0]        in_q,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [INDEX_BITS-1:0]    m_axi_waddr,
  output logic [I_BITS+Q_BITS-1:0] m_axi_wdata,
  output logic                     m_axi_wvalid,
  input  logic                     s_axi_wready,
  input  logic                     s_axi_bresp,
  input  logic                     s_axi_bvalid,
  output logic                     m_axi_bready,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [INDEX_BITS:0]      sample_count
);
  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [INDEX_BITS:0] outstanding;
  logic hold, cap, w_fire, b_fire, spurious, last, restart, keep, take;
  assign cap = state == CAPTURE;
  assign w_fire = m_axi_wvalid && s_axi_wready;
  assign b_fire = s_axi_bvalid && m_axi_bready && outstanding != '0;
  assign spurious = s_axi_bvalid && outstanding == '0 && state != IDLE;
  assign last = cap && w_fire && sample_count == (INDEX_BITS+1)'(BUFFER_LENGTH - 1);
  assign restart = arm && (state == IDLE || state == DONE);
  // hold gives the one-cycle input stall right after the final write is accepted
  assign in_ready = cap ? (!m_axi_wvalid || s_axi_wready) : !hold;
  assign take = cap && in_valid && in_ready && keep && !last;
  assign m_axi_bready = cap || state == DRAIN;
  assign busy = state == ARMED || cap || state == DRAIN;
  assign done = state == DONE;
`ifdef IQ_CAPTURE_WRITER_DECIMATE_EN
  logic [7:0] phase;
  assign keep = phase == '0;
  always_ff @(posedge clk) begin
    if (!reset_n || !cap) phase <= '0;
    else if (in_valid && in_ready) phase <= (phase == 8'(DECIM_FACTOR - 1)) ? '0 : phase + 8'd1;
  end
`else
  // DECIM_FACTOR is 1..255, so every sample is kept
  assign keep = DECIM_FACTOR != 0;
`endif
  always_comb begin
    state_n = restart ? ARMED
            : (state == ARMED && trigger) ? CAPTURE
            : last ? DRAIN
            : (state == DRAIN && outstanding == '0 && !m_axi_wvalid) ? DONE
            : state;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      hold <= 1'b0;
      m_axi_wvalid <= 1'b0;
      m_axi_waddr <= '0;
      m_axi_wdata <= '0;
      sample_count <= '0;
      outstanding <= '0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      hold <= last;
      if (take) begin
        m_axi_wvalid <= 1'b1;
        m_axi_waddr <= INDEX_BITS'(sample_count + (INDEX_BITS+1)'(w_fire));
        m_axi_wdata <= {in_i, in_q};
      end else if (w_fire) begin
        m_axi_wvalid <= 1'b0;
      end
      sample_count <= restart ? '0 : sample_count + (INDEX_BITS+1)'(w_fire);
      error <= restart ? 1'b0 : error | (b_fire && s_axi_bresp) | spurious;
      outstanding <= outstanding + (INDEX_BITS+1)'(w_fire) - (INDEX_BITS+1)'(b_fire);
    end
  end
endmodule

// File: tb/tb_iq_capture_writer.sv
// tb_iq_capture_writer: scoreboard bench for iq_capture_writer with BUFFER_LENGTH=8.
// Expected writes come from the sample stream seen by the bench, decimated when IQ_CAPTURE_WRITER_DECIMATE_EN is set.
module tb_iq_capture_writer;
  localparam int BL = 8;
  localparam int IX = 3;
`ifdef IQ_CAPTURE_WRITER_DECIMATE_EN
  localparam int DF = 3;
  localparam logic [31:0] B1 = 32'h0003_FFFD, B7 = 32'h0015_FFEB;
  localparam logic [31:0] P1 = 32'h0009_FFF7, P7 = 32'h001B_FFE5;
`else
  localparam int DF = 1;
  localparam logic [31:0] B1 = 32'h0001_FFFF, B7 = 32'h0007_FFF9;
  localparam logic [31:0] P1 = 32'h0007_FFF9, P7 = 32'h000D_FFF3;
`endif
  localparam logic [31:0] P0 = 32'h0006_FFFA;
  logic clk = 0, reset_n = 0, arm = 0, trigger = 0, in_valid = 0;
  logic s_axi_wready = 1, s_axi_bresp = 0, s_axi_bvalid = 0;
  logic [15:0] in_i = 0, in_q = 0;
  logic in_ready, m_axi_wvalid, m_axi_bready, busy, done, error;
  logic [IX-1:0] m_axi_waddr;
  logic [31:0] m_axi_wdata;
  logic [IX:0] sample_count;
  int tests = 0, fails = 0, k = 0, pend = 0, rcount = 0, bad = 0;
  int acc = 0, mo = 0, kept = 0, eidx = 0;
  bit took = 0, elig = 0, armed = 0, toggle = 0, spur = 0, err_m = 0, prev_stall = 0;
  logic [IX-1:0] pa;
  logic [31:0] pd;
  logic [31:0] mem [BL];
  int qa [$];
  logic [31:0] qd [$];

  iq_capture_writer #(.I_BITS(16), .Q_BITS(16), .BUFFER_LENGTH(BL), .INDEX_BITS(IX), .DECIM_FACTOR(DF)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .trigger(trigger), .in_i(in_i), .in_q(in_q),
    .in_valid(in_valid), .in_ready(in_ready), .m_axi_waddr(m_axi_waddr), .m_axi_wdata(m_axi_wdata),
    .m_axi_wvalid(m_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .m_axi_bready(m_axi_bready), .busy(busy), .done(done),
    .error(error), .sample_count(sample_count));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Reference model: every consumed post-trigger sample (decimated) becomes the next write, in order.
  always @(negedge clk) begin
    if (!reset_n) begin
      acc = 0; mo = 0; err_m = 0; kept = 0; eidx = 0; pend = 0; took = 0; prev_stall = 0;
      qa.delete(); qd.delete();
    end else begin
      chk("sample_count", sample_count, acc);
      chk("error", error, err_m);
      chk("busy_and_done", busy & done, 0);
      if (prev_stall) begin
        chk("stall_wvalid", m_axi_wvalid, 1);
        chk("stall_waddr", m_axi_waddr, pa);
        chk("stall_wdata", m_axi_wdata, pd);
      end
      if (m_axi_wvalid && !s_axi_wready) chk("stall_in_ready", in_ready, 0);
      if (!busy || armed) chk("idle_in_ready", in_ready, 1);
      if (!busy) chk("idle_bready", m_axi_bready, 0);
      if (done) begin
        chk("done_write_count", acc, BL);
        chk("done_outstanding", mo, 0);
      end
      if (m_axi_wvalid && s_axi_wready) begin
        if (qa.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: addr %0d data %0h, required no write", m_axi_waddr, m_axi_wdata);
        end else begin
          chk("waddr", m_axi_waddr, qa.pop_front());
          chk("wdata", m_axi_wdata, qd.pop_front());
        end
        mem[m_axi_waddr] = m_axi_wdata;
      end
      took = in_valid && in_ready;
      if (took && elig && kept < BL) begin
        if (eidx % DF == 0) begin
          qa.push_back(kept); qd.push_back({in_i, in_q}); kept++;
        end
        eidx++;
      end
      if (s_axi_bvalid && mo == 0 && (busy || done)) err_m = 1;
      if (s_axi_bvalid && m_axi_bready && mo > 0) begin
        if (s_axi_bresp) err_m = 1;
        mo--;
      end
      if (m_axi_wvalid && s_axi_wready) begin acc++; mo++; pend++; end
      if (arm && !busy) begin
        acc = 0; err_m = 0; kept = 0; eidx = 0; qa.delete(); qd.delete();
      end
      prev_stall = m_axi_wvalid && !s_axi_wready;
      pa = m_axi_waddr; pd = m_axi_wdata;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    if (took) k++;
    in_i = 16'(k); in_q = 16'(-k);
    s_axi_wready = toggle ? ~s_axi_wready : 1'b1;
    s_axi_bresp = 0;
    if (spur) s_axi_bvalid = 1;
    else if (pend > 0) begin
      pend--; rcount++;
      s_axi_bvalid = 1; s_axi_bresp = (rcount == bad);
    end else s_axi_bvalid = 0;
    arm = 0; trigger = 0;
  endtask

  task automatic start(input bit tg, input int b, input bit pre);
    for (int a = 0; a < BL; a++) mem[a] = 32'hDEAD_BEEF;
    toggle = tg; bad = b; rcount = 0; elig = 0;
    in_valid = 0; arm = 1;
    cyc();
    k = 0; in_i = 0; in_q = 0; armed = 1;
    @(negedge clk);
    chk("arm_clears_status", {error, done, sample_count}, 0);
    if (pre) begin
      in_valid = 1;
      repeat (5) cyc();
    end
    trigger = 1;
    cyc();
    armed = 0; elig = 1; in_valid = 1;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 300 && !done; n++) cyc();
    @(negedge clk);
    chk("done", done, 1);
  endtask

  task automatic post(input logic [31:0] m0, input logic [31:0] m1, input logic [31:0] m7, input bit e);
    chk("final_count", sample_count, BL);
    chk("final_error", error, e);
    chk("final_busy", busy, 0);
    chk("final_wvalid", m_axi_wvalid, 0);
    chk("mem0", mem[0], m0);
    chk("mem1", mem[1], m1);
    chk("mem7", mem[7], m7);
  endtask

  initial begin
    repeat (2) cyc();
    reset_n = 1;
    @(negedge clk);
    chk("rst_outputs", {busy, done, error, m_axi_wvalid, m_axi_bready, sample_count}, 0);
    chk("rst_in_ready", in_ready, 1);
    start(0, 0, 0); wait_done(); post(0, B1, B7, 0);
    start(1, 0, 0); wait_done(); post(0, B1, B7, 0);
    start(0, 0, 1); wait_done(); post(P0, P1, P7, 0);
    start(0, 3, 0); wait_done(); post(0, B1, B7, 1);
    spur = 1; cyc(); spur = 0; cyc();
    @(negedge clk);
    chk("spurious_sticky_error", error, 1);
    chk("spurious_done", done, 1);
    start(0, 0, 0); wait_done(); post(0, B1, B7, 0);
    start(0, 0, 0);
    for (int n = 0; n < 100 && acc < 4; n++) cyc();
    chk("mid_reached_4_writes", acc >= 4, 1);
    reset_n = 0; elig = 0; armed = 0;
    cyc();
    reset_n = 1;
    @(negedge clk);
    chk("midrst_outputs", {busy, done, error, m_axi_wvalid, sample_count}, 0);
    chk("midrst_in_ready", in_ready, 1);
    start(0, 0, 0); wait_done(); post(0, B1, B7, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
